fnd_scan_controller: RTL and testbench
======================================

Name: fnd_scan_controller

Overview:
- Sequencer for the 4-bit calculator + FND display path.
- Time-multiplexes the four FND digits by driving digit-select and enable, with a blanking gap between digits to suppress ghosting.
- Owns the operand/opcode registers that feed the calculator. New operands are applied only at frame boundaries, so a displayed frame never tears.
- Sits between board inputs (switches, load button strobe) and the calculator/display datapath.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- SCAN_HZ, 1000, digit slot rate in Hz; SCAN_DIV = CLK_HZ/SCAN_HZ cycles per digit slot.
- BLANK_CYC, 1000, blank cycles at the end of each slot; legal range 1 <= BLANK_CYC < SCAN_DIV.
- NUM_DIGITS, 4, number of digits scanned; digit select wraps modulo NUM_DIGITS.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_Run  in  1  scan enable; 0 forces IDLE.
- i_Load  in  1  single-cycle strobe that captures i_A/i_B/i_Sel.
- i_A  in  4  operand A.
- i_B  in  4  operand B.
- i_Sel  in  2  calculator opcode.
- o_A  out  4  registered operand A to the calculator.
- o_B  out  4  registered operand B to the calculator.
- o_Sel  out  2  registered opcode to the calculator.
- o_DigitSelect  out  2  active digit index to the FND decoder.
- o_EN  out  1  FND enable; 0 blanks all digits.
- o_LoadAck  out  1  one-cycle pulse when captured operands reach o_A/o_B/o_Sel.
- o_FrameTick  out  1  one-cycle pulse on each frame boundary.

Behaviour:
- Reset (async assert, sync release): state IDLE; o_A=0, o_B=0, o_Sel=0; o_DigitSelect=0; o_EN=0; o_LoadAck=0; o_FrameTick=0; slot counter=0; shadow registers=0; pending=0. All outputs are registered.
- FSM states are IDLE, DRIVE, BLANK.
- IDLE:
  - o_EN=0, counter=0, digit=0.
  - When i_Run=1, go to DRIVE on the next edge; the first DRIVE cycle has o_EN=1 and digit=0.
- DRIVE:
  - o_EN=1 for SCAN_DIV-BLANK_CYC cycles, then go to BLANK.
- BLANK:
  - o_EN=0 for BLANK_CYC cycles; o_DigitSelect holds its value.
  - On the last BLANK cycle, digit = (digit+1) mod NUM_DIGITS and the FSM returns to DRIVE.
- Frame boundary: the last BLANK cycle of digit NUM_DIGITS-1. o_FrameTick=1 in the cycle after it, aligned with the digit-0 DRIVE start.
- i_Run=0 in any state: IDLE on the next edge; o_EN=0 and digit=0 that same edge. The partial frame is abandoned and no o_FrameTick is issued.
- Load capture:
  - i_Load=1 copies i_A/i_B/i_Sel into the shadow registers and sets pending=1.
  - Loads are accepted in every state.
- Load apply:
  - With pending=1, at a frame boundary or in any IDLE cycle, shadow moves to o_A/o_B/o_Sel on the next edge.
  - pending clears and o_LoadAck pulses for 1 cycle, coincident with the new o_A/o_B/o_Sel values.
- Multiple loads before apply: last load wins; one o_LoadAck only.
- Load in the same cycle as an apply: the apply uses the previous shadow contents. The new values go into the shadow, pending stays 1, and they apply at the next boundary. This gives two acks in total.
- Reset mid-frame or with a pending load: everything returns to reset values and the pending load is discarded.
- The slot counter is wide enough for SCAN_DIV-1 (clog2) and never exceeds SCAN_DIV-1.

Optional Feature:
- Macro: FND_BLANK_GAP_EN.
- Defined: the BLANK state exists as described above.
- Undefined:
  - No BLANK state; DRIVE lasts the full SCAN_DIV cycles, then the digit advances directly.
  - o_EN stays constantly 1 while running.
  - The frame boundary is the last DRIVE cycle of digit NUM_DIGITS-1; BLANK_CYC is ignored.

Decomposition:
- Shared package/header fnd_ctrl_pkg holds:
  - the state encoding (IDLE=2'd0, DRIVE=2'd1, BLANK=2'd2);
  - the SCAN_DIV derivation;
  - the counter-width clog2 function.
- One natural sub-module: scan_slot_counter. It is a parameterised down/up counter with a terminal-count pulse, a sync clear, and a load of the slot length. It is instantiated once for the slot timer.

Test Plan (CLK_HZ=1000, SCAN_HZ=100 => SCAN_DIV=10, BLANK_CYC=2, macro defined):
- Reset then i_Run=1:
  - digit 0 has o_EN=1 for 8 cycles, then 0 for 2 cycles.
  - o_DigitSelect steps 0,1,2,3,0.
  - o_FrameTick fires every 40 cycles.
- i_Load with A=4'h9, B=4'h3, Sel=2'b01 mid-frame (digit 1): o_A/o_B/o_Sel unchanged until the frame boundary, then equal 9/3/01 with a single o_LoadAck aligned with o_FrameTick.
- Two loads (A=1, then A=7) within one frame: only A=7 is applied; exactly one o_LoadAck.
- i_Run dropped during digit 2 DRIVE: next cycle o_EN=0 and o_DigitSelect=0. A pending load (A=5) applies in IDLE with o_LoadAck. No o_FrameTick is issued.
- i_reset_n asserted mid-BLANK with a load pending: all outputs 0 immediately (asynchronous). After release with i_Run=1, scan restarts at digit 0 and no o_LoadAck is ever seen.
- Macro undefined: o_EN stays 1 throughout, each digit lasts 10 cycles, and o_FrameTick fires every 40 cycles.

Source files
------------

// File: rtl/fnd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fnd_ctrl_pkg
// Shared definitions for the FND scan controller:
//   - scan FSM state encoding
//   - slot length derivation (clock cycles per digit slot)
//   - counter width helper (ceil(log2(n)), minimum 1)
// -----------------------------------------------------------------------------
package fnd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_BLANK = 2'd2
  } fnd_state_e;

  // Cycles per digit slot.
  function automatic int scan_div_f(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction

  // Bits needed to hold values 0..n-1.
  function automatic int cnt_width_f(input int n);
    int w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/scan_slot_counter.sv
// -----------------------------------------------------------------------------
// scan_slot_counter
// Loadable down counter used as the digit-slot timer. Loading N-1 gives a
// phase that lasts N cycles; tc flags the final cycle of the phase.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   clr       in   synchronous clear to zero
//   load      in   load load_val (wins over counting)
//   load_val  in   phase length minus one
//   en        in   count enable
//   tc        out  terminal count (count is zero while enabled)
// -----------------------------------------------------------------------------
module scan_slot_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_r;

  // Slot counter register: clear, load, or count down and stick at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= ZERO;
    end else if (clr) begin
      count_r <= ZERO;
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != ZERO)) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = en && (count_r == ZERO);

endmodule

// File: rtl/fnd_scan_controller.sv
// -----------------------------------------------------------------------------
// fnd_scan_controller
// Time-multiplexes the FND digits (DRIVE / BLANK slots) and owns the operand
// registers feeding the calculator. Loaded operands are held in a shadow
// register and only applied at a frame boundary or while idle, so a frame
// never shows mixed operands.
//
// Build option: define FND_BLANK_GAP_EN to insert BLANK_CYC blank cycles at
// the end of every slot. Without it each digit is driven for the whole slot
// and o_EN stays high while running.
//
// Ports:
//   i_clk          in   system clock
//   i_reset_n      in   asynchronous active-low reset
//   i_Run          in   scan enable, 0 forces IDLE
//   i_Load         in   strobe capturing i_A/i_B/i_Sel into the shadow
//   i_A, i_B       in   operands (4 bits)
//   i_Sel          in   opcode (2 bits)
//   o_A, o_B, o_Sel out registered operands/opcode to the calculator
//   o_DigitSelect  out  active digit index
//   o_EN           out  FND enable
//   o_LoadAck      out  pulse when new operands appear on o_A/o_B/o_Sel
//   o_FrameTick    out  pulse in the first cycle of each new frame
// -----------------------------------------------------------------------------
module fnd_scan_controller
  import fnd_ctrl_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int SCAN_HZ    = 1000,
  parameter int BLANK_CYC  = 1000,
  parameter int NUM_DIGITS = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_Run,
  input  logic       i_Load,
  input  logic [3:0] i_A,
  input  logic [3:0] i_B,
  input  logic [1:0] i_Sel,
  output logic [3:0] o_A,
  output logic [3:0] o_B,
  output logic [1:0] o_Sel,
  output logic [1:0] o_DigitSelect,
  output logic       o_EN,
  output logic       o_LoadAck,
  output logic       o_FrameTick
);

`ifdef FND_BLANK_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  localparam int SCAN_DIV  = scan_div_f(CLK_HZ, SCAN_HZ);
  localparam int CW        = cnt_width_f(SCAN_DIV);
  localparam int DRIVE_LEN = GAP_EN ? (SCAN_DIV - BLANK_CYC) : SCAN_DIV;
  localparam logic [CW-1:0] DRIVE_LD = CW'(DRIVE_LEN - 1);
  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYC - 1);
  localparam logic [1:0]    DIG_LAST = 2'(NUM_DIGITS - 1);

  fnd_state_e state_r, state_nxt_s;
  logic [1:0] digit_r, digit_nxt_s, digit_inc_s;
  logic       en_r, tick_r, ack_r, pending_r;
  logic [3:0] a_r, b_r, shadow_a_r, shadow_b_r;
  logic [1:0] sel_r, shadow_sel_r;
  logic       cnt_clr_s, cnt_load_s, cnt_en_s, cnt_tc_s, boundary_s, apply_s;
  logic [CW-1:0] cnt_val_s;

  scan_slot_counter #(.WIDTH(CW)) u_slot_counter (
    .clk      (i_clk),
    .rst_n    (i_reset_n),
    .clr      (cnt_clr_s),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .en       (cnt_en_s),
    .tc       (cnt_tc_s)
  );

  assign cnt_en_s    = (state_r != ST_IDLE);
  assign digit_inc_s = (digit_r == DIG_LAST) ? 2'd0 : (digit_r + 2'd1);

  // Next-state, digit advance, slot timer control and frame-boundary detect.
  always_comb begin
    state_nxt_s = state_r;
    digit_nxt_s = digit_r;
    cnt_clr_s   = 1'b0;
    cnt_load_s  = 1'b0;
    cnt_val_s   = DRIVE_LD;
    boundary_s  = 1'b0;
    if (!i_Run) begin
      state_nxt_s = ST_IDLE;
      digit_nxt_s = 2'd0;
      cnt_clr_s   = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_DRIVE;
          digit_nxt_s = 2'd0;
          cnt_load_s  = 1'b1;
          cnt_val_s   = DRIVE_LD;
        end
        ST_DRIVE: begin
          if (cnt_tc_s) begin
            cnt_load_s = 1'b1;
            if (GAP_EN) begin
              state_nxt_s = ST_BLANK;
              cnt_val_s   = BLANK_LD;
            end else begin
              // No gap: the last drive cycle closes the slot.
              state_nxt_s = ST_DRIVE;
              digit_nxt_s = digit_inc_s;
              cnt_val_s   = DRIVE_LD;
              boundary_s  = (digit_r == DIG_LAST);
            end
          end else begin
            state_nxt_s = ST_DRIVE;
          end
        end
        ST_BLANK: begin
          if (cnt_tc_s) begin
            state_nxt_s = ST_DRIVE;
            digit_nxt_s = digit_inc_s;
            cnt_load_s  = 1'b1;
            cnt_val_s   = DRIVE_LD;
            boundary_s  = (digit_r == DIG_LAST);
          end else begin
            state_nxt_s = ST_BLANK;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          digit_nxt_s = 2'd0;
          cnt_clr_s   = 1'b1;
        end
      endcase
    end
  end

  // Shadow contents go live when a frame completes or while idle.
  assign apply_s = pending_r && ((state_r == ST_IDLE) || boundary_s);

  // Scan state and registered display outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r <= ST_IDLE;
      digit_r <= 2'd0;
      en_r    <= 1'b0;
      tick_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      digit_r <= digit_nxt_s;
      en_r    <= (state_nxt_s == ST_DRIVE);
      tick_r  <= boundary_s;
    end
  end

  // Operand capture into shadow and frame-aligned apply to the outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      a_r          <= 4'd0;
      b_r          <= 4'd0;
      sel_r        <= 2'd0;
      shadow_a_r   <= 4'd0;
      shadow_b_r   <= 4'd0;
      shadow_sel_r <= 2'd0;
      pending_r    <= 1'b0;
      ack_r        <= 1'b0;
    end else begin
      if (apply_s) begin
        a_r   <= shadow_a_r;
        b_r   <= shadow_b_r;
        sel_r <= shadow_sel_r;
      end
      // A load coinciding with an apply refills the shadow and stays pending.
      if (i_Load) begin
        shadow_a_r   <= i_A;
        shadow_b_r   <= i_B;
        shadow_sel_r <= i_Sel;
        pending_r    <= 1'b1;
      end else if (apply_s) begin
        pending_r <= 1'b0;
      end
      ack_r <= apply_s;
    end
  end

  assign o_A           = a_r;
  assign o_B           = b_r;
  assign o_Sel         = sel_r;
  assign o_DigitSelect = digit_r;
  assign o_EN          = en_r;
  assign o_LoadAck     = ack_r;
  assign o_FrameTick   = tick_r;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for fnd_scan_controller. A reference model computes the
// expected display position from the number of cycles since the scan started
// and tracks the shadow/pending operand state; a separate monitor compares.
module tb_fnd_scan_controller;

  localparam int CLK_HZ     = 1000;
  localparam int SCAN_HZ    = 100;
  localparam int BLANK_CYC  = 2;
  localparam int NUM_DIGITS = 4;
  localparam int SCAN_DIV   = CLK_HZ / SCAN_HZ;
  localparam int FRAME      = SCAN_DIV * NUM_DIGITS;
`ifdef FND_BLANK_GAP_EN
  localparam int DRIVE_LEN  = SCAN_DIV - BLANK_CYC;
`else
  localparam int DRIVE_LEN  = SCAN_DIV;
`endif

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_Run = 1'b0, i_Load = 1'b0;
  logic [3:0] i_A = 4'd0, i_B = 4'd0;
  logic [1:0] i_Sel = 2'd0;
  logic [3:0] o_A, o_B;
  logic [1:0] o_Sel, o_DigitSelect;
  logic       o_EN, o_LoadAck, o_FrameTick;

  fnd_scan_controller #(
    .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLANK_CYC(BLANK_CYC), .NUM_DIGITS(NUM_DIGITS)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_Run(i_Run), .i_Load(i_Load),
    .i_A(i_A), .i_B(i_B), .i_Sel(i_Sel), .o_A(o_A), .o_B(o_B), .o_Sel(o_Sel),
    .o_DigitSelect(o_DigitSelect), .o_EN(o_EN), .o_LoadAck(o_LoadAck),
    .o_FrameTick(o_FrameTick)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed { logic [3:0] a; logic [3:0] b; logic [1:0] sel; } opnd_t;
  typedef struct packed { logic en; logic [1:0] dig; logic tick; logic ack; opnd_t op; } exp_t;

  exp_t  exp_q[$];
  opnd_t ack_q[$];
  int    n_chk = 0, n_err = 0, n_ack_exp = 0, n_ack_seen = 0;

  // model state
  bit    m_run = 1'b0, m_pend = 1'b0, m_boundary, m_apply;
  int    m_k = 0;
  opnd_t m_shadow = '0, m_out = '0;
  exp_t  m_e, mon_e;
  opnd_t mon_o;

  task automatic chk(input string name, input int act, input int want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: position k counts cycles since the scan started.
  initial forever begin
    @(posedge i_clk or negedge i_reset_n);
    if (!i_reset_n) begin
      m_run = 1'b0; m_k = 0; m_pend = 1'b0; m_shadow = '0; m_out = '0;
      n_ack_exp = n_ack_exp - ack_q.size();
      exp_q.delete(); ack_q.delete();
    end else begin
      m_boundary = m_run && i_Run && ((m_k % FRAME) == FRAME - 1);
      m_apply    = m_pend && (!m_run || m_boundary);
      if (m_apply) begin
        m_out = m_shadow;
        ack_q.push_back(m_shadow);
        n_ack_exp++;
      end
      if (i_Load) begin
        m_shadow = {i_A, i_B, i_Sel};
        m_pend   = 1'b1;
      end else if (m_apply) begin
        m_pend = 1'b0;
      end
      m_k   = (m_run && i_Run) ? m_k + 1 : 0;
      m_run = i_Run;
      m_e.en   = m_run && ((m_k % SCAN_DIV) < DRIVE_LEN);
      m_e.dig  = m_run ? 2'((m_k / SCAN_DIV) % NUM_DIGITS) : 2'd0;
      m_e.tick = m_boundary;
      m_e.ack  = m_apply;
      m_e.op   = m_out;
      exp_q.push_back(m_e);
    end
  end

  // Monitor: compares every presented cycle and every load acknowledge.
  initial forever begin
    @(negedge i_clk);
    if (i_reset_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("en", int'(o_EN), int'(mon_e.en));
      chk("digit", int'(o_DigitSelect), int'(mon_e.dig));
      chk("frame_tick", int'(o_FrameTick), int'(mon_e.tick));
      chk("load_ack", int'(o_LoadAck), int'(mon_e.ack));
      chk("operands", int'({o_A, o_B, o_Sel}), int'(mon_e.op));
    end
    if (i_reset_n && o_LoadAck) begin
      n_ack_seen++;
      if (ack_q.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        mon_o = ack_q.pop_front();
        chk("ack_operands", int'({o_A, o_B, o_Sel}), int'(mon_o));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #2;
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
    i_A = a; i_B = b; i_Sel = sel; i_Load = 1'b1;
    step(1);
    i_Load = 1'b0;
  endtask

  task automatic wait_for(input logic [1:0] dig, input logic en, input string name);
    int t;
    t = 0;
    while (!(o_DigitSelect == dig && o_EN == en) && t < 200) begin
      step(1);
      t++;
    end
    chk(name, int'(t < 200), 1);
  endtask

  task automatic check_zero(input string name);
    chk(name, int'({o_A, o_B, o_Sel, o_DigitSelect, o_EN, o_LoadAck, o_FrameTick}), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base;

  initial begin
    repeat (3) @(posedge i_clk);
    #2;
    check_zero("reset_state");
    i_reset_n = 1'b1;
    i_Run = 1'b1;
    step(1);
    chk("first_drive_en", int'(o_EN), 1);
    chk("first_drive_digit", int'(o_DigitSelect), 0);
    step(45);

    // load during digit 1 applies at the frame boundary
    wait_for(2'd1, 1'b1, "wait_digit1");
    base = n_ack_seen;
    load(4'h9, 4'h3, 2'b01);
    step(45);
    chk("load1_ack_count", n_ack_seen - base, 1);
    chk("load1_value", int'({o_A, o_B, o_Sel}), int'({4'h9, 4'h3, 2'b01}));

    // two loads in one frame: last wins, single ack
    wait_for(2'd0, 1'b1, "wait_digit0");
    base = n_ack_seen;
    load(4'h1, 4'h2, 2'b10);
    step(5);
    load(4'h7, 4'h2, 2'b10);
    step(45);
    chk("load2_ack_count", n_ack_seen - base, 1);
    chk("load2_a", int'(o_A), 7);

    // run dropped during digit 2 with a pending load
    wait_for(2'd2, 1'b1, "wait_digit2");
    base = n_ack_seen;
    load(4'h5, 4'h5, 2'b11);
    i_Run = 1'b0;
    step(1);
    chk("stop_en", int'(o_EN), 0);
    chk("stop_digit", int'(o_DigitSelect), 0);
    step(3);
    chk("idle_apply_ack", n_ack_seen - base, 1);
    chk("idle_apply_a", int'(o_A), 5);

    // reset mid-BLANK (or mid-slot without a gap) with a pending load
    i_Run = 1'b1;
`ifdef FND_BLANK_GAP_EN
    wait_for(2'd1, 1'b0, "wait_blank");
`else
    wait_for(2'd1, 1'b1, "wait_digit1_again");
`endif
    load(4'h6, 4'h6, 2'b10);
    i_reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    step(2);
    i_reset_n = 1'b1;
    base = n_ack_seen;
    step(1);
    chk("restart_digit", int'(o_DigitSelect), 0);
    step(60);
    chk("no_ack_after_reset", n_ack_seen - base, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      i_Run  = ($urandom_range(0, 29) != 0);
      i_Load = ($urandom_range(0, 7) == 0);
      i_A    = 4'($urandom);
      i_B    = 4'($urandom);
      i_Sel  = 2'($urandom);
      step(1);
    end
    i_Load = 1'b0;
    i_Run  = 1'b1;
    step(50);
    chk("ack_queue_drained", ack_q.size(), 0);
    chk("ack_total", n_ack_seen, n_ack_exp);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
